// File: rtl/mem_arr_rd_sched.sv
// Read sequencer for the per-row SRAM bank array feeding the systolic array.
// Optional diagonal row skew is enabled with `define MEM_RD_SKEW_EN.
module mem_arr_rd_sched #(
  parameter int SYS_ROW    = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  stall,
  output logic [SYS_ROW-1:0]    rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr [0:SYS_ROW-1],
  output logic [SYS_ROW-1:0]    rd_valid,
  output logic                  busy,
  output logic                  done
);

`ifdef MEM_RD_SKEW_EN
  localparam int unsigned SKEW = 1;
`else
  localparam int unsigned SKEW = 0;
`endif

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TW    = $clog2(DEPTH + SYS_ROW) + 1;
  localparam logic [ADDR_WIDTH:0] LEN_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [TW-1:0]       SKEW_SPAN = TW'((SYS_ROW - 1) * SKEW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                state_q;
  logic [TW-1:0]         t_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [SYS_ROW-1:0]    rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q [0:SYS_ROW-1];
  logic [SYS_ROW-1:0]    rd_valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ADDR_WIDTH:0]   len_clamp;
  logic [TW-1:0]         iss_t;
  logic [ADDR_WIDTH-1:0] iss_base;
  logic [ADDR_WIDTH:0]   iss_len;
  logic [TW-1:0]         last_t;
  logic [SYS_ROW-1:0]    en_d;
  logic [ADDR_WIDTH-1:0] addr_d [0:SYS_ROW-1];

  assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
  // t_q == last_t means every row has issued its final read
  assign last_t    = TW'(len_q) + SKEW_SPAN;

  // The accept edge issues step 0 straight from the inputs so row 0 reads
  // in the cycle right after start; later steps come from the latched command.
  always_comb begin
    iss_t    = (state_q == IDLE) ? '0 : t_q;
    iss_base = (state_q == IDLE) ? base_addr : base_q;
    iss_len  = (state_q == IDLE) ? len_clamp : len_q;
    for (int i = 0; i < SYS_ROW; i++) begin
      en_d[i]   = (iss_t >= TW'(i * SKEW)) &&
                  ((iss_t - TW'(i * SKEW)) < TW'(iss_len));
      addr_d[i] = iss_base + ADDR_WIDTH'(iss_t - TW'(i * SKEW));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      t_q        <= '0;
      base_q     <= '0;
      len_q      <= '0;
      rd_en_q    <= '0;
      rd_valid_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < SYS_ROW; i++) rd_addr_q[i] <= '0;
    end else begin
      rd_valid_q <= rd_en_q;
      rd_en_q    <= '0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_clamp != '0) begin
              base_q  <= base_addr;
              len_q   <= len_clamp;
              t_q     <= TW'(1);
              rd_en_q <= en_d;
              busy_q  <= 1'b1;
              state_q <= RUN;
              for (int i = 0; i < SYS_ROW; i++)
                if (en_d[i]) rd_addr_q[i] <= addr_d[i];
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // Stall freezes t and the addresses; enables drop to zero.
          if (!stall) begin
            if (t_q == last_t) begin
              state_q <= DRAIN;
            end else begin
              rd_en_q <= en_d;
              t_q     <= t_q + TW'(1);
              for (int i = 0; i < SYS_ROW; i++)
                if (en_d[i]) rd_addr_q[i] <= addr_d[i];
            end
          end
        end
        DRAIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
